breadboard_sweep_ctrl: RTL and testbench

//  Sequencer that owns the 4-input/10-output Breadboard logic-function unit.
//  On start: drives all input vectors in ascending order, waits a settle window, captures the 10 outputs.

---
 rtl/bb_sweep_pkg.sv | 11 +
 rtl/bb_golden_rom.sv | 9 +
 rtl/breadboard_sweep_ctrl.sv | 109 ++++++++++
 tb/tb_breadboard_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bb_sweep_pkg.sv
// bb_sweep_pkg: shared widths, sweep FSM state type and golden Breadboard response table
package bb_sweep_pkg;
    localparam int BB_IN_W  = 4;
    localparam int BB_OUT_W = 10;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} bb_state_t;
    // Entry k is the expected {f9..f0} for input vector k; entry 15 is listed first
    localparam logic [15:0][BB_OUT_W-1:0] BB_GOLDEN = {
        10'h266, 10'h3A2, 10'h18F, 10'h24B, 10'h37C, 10'h0D4, 10'h2B9, 10'h128,
        10'h3F1, 10'h06E, 10'h335, 10'h15A, 10'h2E5, 10'h1C3, 10'h0A7, 10'h194
    };
endpackage

// File: rtl/bb_golden_rom.sv
// bb_golden_rom: maps a vector index to the Breadboard's expected 10-bit response
module bb_golden_rom
    import bb_sweep_pkg::*;
(
    input  logic [BB_IN_W-1:0]  i_idx,
    output logic [BB_OUT_W-1:0] o_data
);
    assign o_data = BB_GOLDEN[i_idx];
endmodule

// File: rtl/breadboard_sweep_ctrl.sv
// breadboard_sweep_ctrl: steps the Breadboard through every input vector and streams the captured outputs
// Define BB_SWEEP_CHECK_EN to compare each capture against the golden table and count mismatches.
module breadboard_sweep_ctrl
    import bb_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int NUM_VEC       = 16
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [BB_IN_W-1:0]  bb_in,
    input  logic [BB_OUT_W-1:0] bb_r,
    output logic                cap_valid,
    output logic [BB_IN_W-1:0]  cap_idx,
    output logic [BB_OUT_W-1:0] cap_data,
    output logic                err,
    output logic [4:0]          err_count
);
    localparam logic [7:0]         LAST_CNT = 8'(SETTLE_CYCLES - 1);
    localparam logic [BB_IN_W-1:0] LAST_IDX = BB_IN_W'(NUM_VEC - 1);

    bb_state_t          r_state, w_state_nxt;
    logic [7:0]         r_cnt;
    logic [BB_IN_W-1:0] r_idx;
    logic               r_done;
    logic               w_go, w_cap, w_cap_ok;

    assign w_go     = (r_state == ST_IDLE) && start && !abort;
    assign w_cap    = (r_state == ST_SETTLE) && (r_cnt == LAST_CNT);
    assign w_cap_ok = w_cap && !abort;
    assign busy     = (r_state == ST_SETTLE);
    assign done     = r_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: abort drops a running sweep back to IDLE, the final capture moves on to DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_go ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: w_state_nxt = abort ? ST_IDLE : (w_cap && r_idx == LAST_IDX) ? ST_DONE : ST_SETTLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Vector sequencing, capture strobe and the done pulse one cycle after DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            bb_in     <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            cap_data  <= '0;
        end else begin
            cap_valid <= w_cap_ok;
            r_done    <= (r_state == ST_DONE) && !abort;
            if (w_go) begin
                r_cnt <= '0;
                r_idx <= '0;
                bb_in <= '0;
            end else if (r_state == ST_SETTLE && !abort) begin
                if (!w_cap) begin
                    r_cnt <= r_cnt + 8'd1;
                end else begin
                    cap_idx  <= r_idx;
                    cap_data <= bb_r;
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + 1'b1;
                        bb_in <= r_idx + 1'b1;
                        r_cnt <= '0;
                    end
                end
            end
        end
    end

`ifdef BB_SWEEP_CHECK_EN
    logic [BB_OUT_W-1:0] w_gold;
    logic                w_miss;

    bb_golden_rom u_rom (.i_idx(r_idx), .o_data(w_gold));

    assign w_miss = w_cap_ok && (bb_r != w_gold);

    // Sticky mismatch flag and saturating mismatch count, cleared when a sweep starts
    always_ff @(posedge clk) begin
        if (rst || w_go) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (w_miss) begin
            err       <= 1'b1;
            err_count <= (err_count == 5'd16) ? err_count : err_count + 5'd1;
        end
    end
`else
    assign err       = 1'b0;
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// tb_breadboard_sweep_ctrl: scoreboard bench for the sweep controller driving a modelled Breadboard
module tb_breadboard_sweep_ctrl;
    localparam int NV = 16;
    localparam int SA = 3;
    localparam int SB = 1;
`ifdef BB_SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [9:0] TBL [16] = '{
        10'h194, 10'h0A7, 10'h1C3, 10'h2E5, 10'h15A, 10'h335, 10'h06E, 10'h3F1,
        10'h128, 10'h2B9, 10'h0D4, 10'h37C, 10'h24B, 10'h18F, 10'h3A2, 10'h266
    };

    typedef struct {
        bit is_done;
        int cyc;
        int idx;
        int data;
        int ecnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_start = 1'b0, a_abort = 1'b0, a_inj = 1'b0;
    logic       a_busy, a_done, a_cap_valid, a_err;
    logic [3:0] a_bb_in, a_cap_idx;
    logic [9:0] a_bb_r, a_cap_data;
    logic [4:0] a_err_count;
    logic       b_start = 1'b0, b_abort = 1'b0;
    logic       b_busy, b_done, b_cap_valid, b_err;
    logic [3:0] b_bb_in, b_cap_idx;
    logic [9:0] b_bb_r, b_cap_data;
    logic [4:0] b_err_count;

    int   cyc = 0;
    int   t0 = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    logic [9:0] a_last [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit flt(int k, bit inj);
        return inj && (k == 3 || k == 9);
    endfunction

    // Breadboard stand-in: table lookup, with bit0 optionally corrupted on vectors 3 and 9
    assign a_bb_r = TBL[a_bb_in] ^ {9'd0, flt(int'(a_bb_in), a_inj)};
    assign b_bb_r = TBL[b_bb_in];

    breadboard_sweep_ctrl #(.SETTLE_CYCLES(SA), .NUM_VEC(NV)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .busy(a_busy), .done(a_done),
        .bb_in(a_bb_in), .bb_r(a_bb_r), .cap_valid(a_cap_valid), .cap_idx(a_cap_idx),
        .cap_data(a_cap_data), .err(a_err), .err_count(a_err_count)
    );

    breadboard_sweep_ctrl #(.SETTLE_CYCLES(SB), .NUM_VEC(NV)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
        .bb_in(b_bb_in), .bb_r(b_bb_r), .cap_valid(b_cap_valid), .cap_idx(b_cap_idx),
        .cap_data(b_cap_data), .err(b_err), .err_count(b_err_count)
    );

    function automatic void chk(string n, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    // Expected event: capture k (or done) at a given cycle; mismatch count is faults among indices 0..k
    function automatic ev_t mk(bit d, int c, int k, bit inj);
        ev_t e;
        int  n = 0;
        for (int j = 0; j <= k; j++) n += int'(flt(j, inj));
        e.is_done = d;
        e.cyc     = c;
        e.idx     = k;
        e.data    = int'(TBL[k] ^ {9'd0, flt(k, inj)});
        e.ecnt    = CHK ? n : 0;
        return e;
    endfunction

    always @(negedge clk) begin : mon_a
        ev_t e;
        if (a_cap_valid || a_done) begin
            if (qa.size() == 0) chk("a_unexpected_event", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_kind", int'(a_done), int'(e.is_done));
                chk("a_cycle", cyc, e.cyc);
                if (!e.is_done) begin
                    chk("a_cap_idx", int'(a_cap_idx), e.idx);
                    chk("a_cap_data", int'(a_cap_data), e.data);
                    a_last[a_cap_idx] = a_cap_data;
                end
                chk("a_err_count", int'(a_err_count), e.ecnt);
                chk("a_err", int'(a_err), int'(e.ecnt != 0));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t e;
        if (b_cap_valid || b_done) begin
            if (qb.size() == 0) chk("b_unexpected_event", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_kind", int'(b_done), int'(e.is_done));
                chk("b_cycle", cyc, e.cyc);
                if (!e.is_done) begin
                    chk("b_cap_idx", int'(b_cap_idx), e.idx);
                    chk("b_cap_data", int'(b_cap_data), e.data);
                end
                chk("b_err_count", int'(b_err_count), 0);
            end
        end
    end

    task automatic start_a(input bit inj, input bit hold);
        @(negedge clk);
        a_inj   = inj;
        a_start = 1'b1;
        t0      = cyc + 1;
        for (int k = 0; k < NV; k++) qa.push_back(mk(1'b0, t0 + (k + 1) * SA, k, inj));
        qa.push_back(mk(1'b1, t0 + NV * SA + 1, NV - 1, inj));
        @(negedge clk);
        if (!hold) a_start = 1'b0;
        chk("a_busy_after_start", int'(a_busy), 1);
    endtask

    task automatic zero_a();
        chk("a_zero_busy", int'(a_busy), 0);
        chk("a_zero_done", int'(a_done), 0);
        chk("a_zero_cap_valid", int'(a_cap_valid), 0);
        chk("a_zero_cap_idx", int'(a_cap_idx), 0);
        chk("a_zero_cap_data", int'(a_cap_data), 0);
        chk("a_zero_bb_in", int'(a_bb_in), 0);
        chk("a_zero_err", int'(a_err), 0);
        chk("a_zero_err_count", int'(a_err_count), 0);
    endtask

    // Abort or reset sampled at edge e; everything the model scheduled from e onward is cancelled
    task automatic hit_a(input int e, input bit is_rst);
        while (cyc < e - 1) @(negedge clk);
        if (is_rst) rst = 1'b1;
        else a_abort = 1'b1;
        while (qa.size() > 0 && qa[qa.size() - 1].cyc >= e) qa.delete(qa.size() - 1);
        @(negedge clk);
        rst     = 1'b0;
        a_abort = 1'b0;
        chk("a_busy_after_hit", int'(a_busy), 0);
        if (is_rst) zero_a();
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", qa.size() + qb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        zero_a();
        chk("b_zero_busy", int'(b_busy), 0);
        chk("b_zero_bb_in", int'(b_bb_in), 0);

        // full sweep, settle 3: captures every 3 cycles, done 49 cycles after start
        start_a(1'b0, 1'b0);
        drain();
        chk("a_idx0_data", int'(a_last[0]), 'h194);
        chk("a_idx5_data", int'(a_last[5]), 'h335);
        chk("a_idx15_data", int'(a_last[15]), 'h266);

        // settle 1: back-to-back captures, done the cycle after the last one
        @(negedge clk);
        b_start = 1'b1;
        t0      = cyc + 1;
        for (int k = 0; k < NV; k++) qb.push_back(mk(1'b0, t0 + k + 1, k, 1'b0));
        qb.push_back(mk(1'b1, t0 + NV + 1, NV - 1, 1'b0));
        @(negedge clk);
        b_start = 1'b0;
        chk("b_busy_after_start", int'(b_busy), 1);
        drain();

        // abort just after the idx 4 capture, then a fresh sweep from idx 0
        start_a(1'b0, 1'b0);
        hit_a(t0 + 5 * SA + 1, 1'b0);
        repeat (4) @(negedge clk);
        start_a(1'b0, 1'b0);
        drain();

        // start held through the whole sweep gives one sweep; start+abort in IDLE does nothing
        start_a(1'b0, 1'b1);
        n = 0;
        while (!a_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_held_start_done_seen", int'(a_done), 1);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_held_start_single", int'(a_busy), 0);
        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        chk("a_start_abort_idle", int'(a_busy), 0);
        a_start = 1'b0;
        a_abort = 1'b0;
        drain();

        // reset in the middle of idx 7, then silence until a fresh start
        start_a(1'b0, 1'b0);
        hit_a(t0 + 7 * SA + 1, 1'b1);
        repeat (60) @(negedge clk);
        drain();

        // corrupted vectors 3 and 9
        start_a(1'b1, 1'b0);
        drain();
        chk("a_err_count_final", int'(a_err_count), CHK ? 2 : 0);
        chk("a_err_final", int'(a_err), CHK ? 1 : 0);

        // randomized sweeps with random corruption, aborts and resets
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            start_a(1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) hit_a(t0 + int'($urandom_range(1, NV * SA + 1)), $urandom_range(0, 3) == 0);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
